// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch slice.
package fetch_pkg;

  // Default address width and first fetch address after reset.
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Width of one instruction word returned by memory.
  localparam int          INSTR_W  = 32;

  // One queue entry: the fetch address paired with the word returned for it.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both as the instruction queue and as the
// in-flight address tracker. DEPTH must be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pop only when something is stored; push when there is room or a pop
  // frees a slot in the same cycle (so full + push + pop keeps the count).
  assign w_do_pop   = i_pop && (r_count != ZERO_CNT);
  assign w_do_push  = i_push && ((r_count != FULL_CNT) || w_do_pop);
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Entry storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_reset && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Read/write pointers and occupancy; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= ZERO_CNT;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_unit_chk.sv
// Protocol and invariant checks for prefetch_unit.
module prefetch_unit_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          rsp_valid,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] discard_cnt,
  input logic [CW-1:0] q_count
);

  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  // Memory must not answer when nothing is in flight.
  a_rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(rsp_valid && (outstanding == {CW{1'b0}})));

  // Credit rule: in-flight plus queued never exceeds the queue depth.
  a_credit: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, outstanding} + {1'b0, q_count}) <= LIMIT));

  // Only requests that are actually in flight can be marked for discard.
  a_discard_le_outstanding: assert property (@(posedge clk) disable iff (reset)
    (discard_cnt <= outstanding));

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetches under a credit rule,
// pairs returned words with their addresses and queues them for decode.
// Redirects flush the queue and mark in-flight responses for discard.
module prefetch_unit #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc_plus4
);

  localparam int            INSTR_W    = fetch_pkg::INSTR_W;
  localparam int            ENTRY_W    = XLEN + INSTR_W;
  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW:0]   CREDIT_LIM = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  logic [XLEN-1:0]    r_pc;
  logic [CW-1:0]      r_discard;
  logic [CW-1:0]      w_outstanding;
  logic [CW-1:0]      w_q_count;
  logic [XLEN-1:0]    w_trk_pc;
  logic [ENTRY_W-1:0] w_head;
  logic               w_credit;
  logic               w_accept;
  logic               w_rsp_ok;
  logic               w_q_push;
  logic               w_q_pop;

  // A response with nothing in flight is a protocol error and is ignored.
  assign w_rsp_ok = imem_rsp_valid && (w_outstanding != CNT_ZERO);
  assign w_credit = (({1'b0, w_outstanding} + {1'b0, w_q_count}) < CREDIT_LIM);

  assign imem_req_valid = !reset && !redirect_valid && w_credit;
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // Responses are kept only when not marked for discard and no redirect is
  // flushing the queue this cycle.
  assign w_q_push = w_rsp_ok && (r_discard == CNT_ZERO) && !redirect_valid;
  assign w_q_pop  = out_valid && out_ready;

  assign out_valid    = (w_q_count != CNT_ZERO);
  assign out_pc       = w_head[ENTRY_W-1:INSTR_W];
  assign out_instr    = w_head[INSTR_W-1:0];
  assign out_pc_plus4 = out_pc + PC_STEP;

  // In-flight address tracker: its occupancy is the outstanding count and
  // its head is the address of the next response. Redirects do not flush it
  // because those responses still arrive and must be consumed.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk         (clk),
    .i_reset     (reset),
    .i_flush     (1'b0),
    .i_push      (w_accept),
    .i_push_data (r_pc),
    .i_pop       (w_rsp_ok),
    .o_pop_data  (w_trk_pc),
    .o_count     (w_outstanding)
  );

  // Instruction queue of {pc, instr}; a redirect empties it after any pop.
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .i_reset     (reset),
    .i_flush     (redirect_valid),
    .i_push      (w_q_push),
    .i_push_data ({w_trk_pc, imem_rsp_data}),
    .i_pop       (w_q_pop),
    .o_pop_data  (w_head),
    .o_count     (w_q_count)
  );

  // Fetch PC: reset value, redirect target, or sequential advance on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_accept) begin
      r_pc <= r_pc + PC_STEP;
    end else begin
      r_pc <= r_pc;
    end
  end

  // Discard count: on redirect every request still in flight after this
  // cycle's response becomes stale (no accept happens during a redirect).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_discard <= CNT_ZERO;
    end else if (redirect_valid) begin
      r_discard <= w_rsp_ok ? (w_outstanding - CNT_ONE) : w_outstanding;
    end else if (w_rsp_ok && (r_discard != CNT_ZERO)) begin
      r_discard <= r_discard - CNT_ONE;
    end else begin
      r_discard <= r_discard;
    end
  end

  prefetch_unit_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .rsp_valid   (imem_rsp_valid),
    .outstanding (w_outstanding),
    .discard_cnt (r_discard),
    .q_count     (w_q_count)
  );

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning PC/address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning instruction-queue entries; a power of two, at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 The block SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 The block SHALL have port imem_req_addr  output  XLEN  fetch address, equal to the internal fetch PC.
REQ-009 The block SHALL have port imem_rsp_valid  input  1  instruction word returned this cycle; responses arrive in request order, at least 1 cycle after acceptance.
REQ-010 The block SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-011 The block SHALL have port redirect_valid  input  1  branch/jump redirect that flushes the block.
REQ-012 The block SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-013 The block SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-014 The block SHALL have port out_ready  input  1  decode accepts the head this cycle.
REQ-015 The block SHALL have port out_pc  output  XLEN  PC of the head instruction.
REQ-016 The block SHALL have port out_instr  output  32  head instruction word.
REQ-017 The block SHALL have port out_pc_plus4  output  XLEN  out_pc + 4, modulo 2^XLEN.

Function
REQ-018 Request rule: imem_req_valid SHALL be 1 iff reset=0, redirect_valid=0 and outstanding + queue_count < DEPTH (credit rule; the queue never overflows).
REQ-019 On acceptance (imem_req_valid & imem_req_ready), the fetch PC SHALL advance by 4, wrapping modulo 2^XLEN, and outstanding SHALL increment.
REQ-020 Each in-flight request SHALL record its address in order, so that the returned word is paired with its PC.
REQ-021 A response with discard_cnt = 0 SHALL push {pc, instr} into the queue; a response with discard_cnt > 0 SHALL be dropped and SHALL decrement discard_cnt. Either case SHALL decrement outstanding.
REQ-022 Output: out_valid = (queue_count > 0); the head SHALL be stable while out_valid & !out_ready; pop on out_valid & out_ready.
REQ-023 Simultaneous push and pop SHALL keep queue_count unchanged, including when the queue is full.
REQ-024 A new queue entry SHALL reach out_valid no earlier than 1 cycle after the response (registered queue, no bypass).
REQ-025 On redirect_valid, the next-cycle state SHALL be: fetch PC = redirect_pc; queue emptied; discard_cnt = outstanding after this cycle's response and acceptance are applied.
REQ-026 A pop in the redirect cycle SHALL complete (the head is older than the redirect); a response in the redirect cycle SHALL be dropped.
REQ-027 Back-to-back redirects SHALL each be honoured; the last one sets the fetch PC.
REQ-028 Counter widths SHALL be $clog2(DEPTH)+1 bits; outstanding and discard_cnt SHALL never exceed DEPTH.
REQ-029 A response arriving with outstanding = 0 is a protocol error; it SHALL be ignored, and an assertion SHALL flag it.

Reset
REQ-030 While reset=1: fetch PC SHALL be RESET_PC; queue_count, outstanding and discard_cnt SHALL be 0; out_valid = 0; imem_req_valid = 0.
REQ-031 Reset during in-flight requests SHALL discard all state, and responses for pre-reset requests SHALL NOT occur (the memory is reset with the block).
REQ-032 The first request SHALL assert in the first cycle after reset deasserts, with imem_req_addr = RESET_PC.

Structure
REQ-033 Shared package fetch_pkg SHALL hold XLEN, RESET_PC and typedef fetch_entry_t {pc, instr}.
REQ-034 The queue SHALL be a sub-module fetch_fifo (parametrised width/DEPTH, push/pop/count); the in-flight PC tracker MAY reuse fetch_fifo.

Verification
REQ-035 Reset, then memory ready, 1-cycle latency, out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, ... with matching out_instr; out_pc_plus4 = out_pc+4.
REQ-036 out_ready=0 with DEPTH=4 -> exactly 4 accepted requests, then imem_req_valid=0; out_ready=1 for one cycle -> exactly one further request.
REQ-037 Redirect to 0x100 with 3 requests outstanding -> the 3 responses are dropped, and the next out_pc is 0x100.
REQ-038 Redirect in the same cycle as a pop and a response -> the pop completes, the response is dropped, and no stale PC is ever output.
REQ-039 Fetch PC at 0xFFFF_FFFC (XLEN=32) -> the next request address is 0x0; out_pc_plus4 = 0x0.
REQ-040 Reset asserted mid-stream with the queue full -> next cycle out_valid=0 and imem_req_valid=0; after release, fetch restarts at RESET_PC.
